// File: rtl/smvm_pkg.sv
// rtl/smvm_pkg.sv - shared types and constants for the SMVM stream transmitter
//
// Holds the ALU group size, field widths, the transmitter state encoding,
// the nonzero FIFO entry layout and the 9-bit-to-beat split helper.
package smvm_pkg;

    localparam int K     = 4;
    localparam int IDX_W = 9;
    localparam int VAL_W = 8;
    localparam int OUT_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR0,
        ST_HDR1,
        ST_VEC,
        ST_VAL,
        ST_IDX,
        ST_GAP
    } tx_state_t;

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [IDX_W-1:0] col;
        logic             last;
    } nz_entry_t;

    // A 9-bit quantity travels as one beat: upper 8 bits on val_out, LSB on ipv_out.
    function automatic logic [VAL_W:0] split9(input logic [IDX_W-1:0] v);
        return {v[IDX_W-1:1], v[0]};
    endfunction

endpackage

// File: rtl/smvm_nz_fifo.sv
// rtl/smvm_nz_fifo.sv - show-ahead synchronous FIFO for buffered nonzero entries
//
// Ports: clk, rst_n (async, active-low), i_push/i_data write side,
//        i_pop/o_data read side (o_data is the current head), o_full, o_empty.
module smvm_nz_fifo #(
    parameter int DEPTH = 64,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/smvm_stream_tx.sv
// rtl/smvm_stream_tx.sv - buffers one SMVM job and emits it as a gap-free frame
//
// Ports: clk, rst_n (async, active-low); s_start/s_rows/s_cols job header;
//        s_vec_* vector element handshake; s_nz_* nonzero handshake;
//        val_out/ipv_out/out_valid SMVM input stream; busy; err_col.
// Optional build macro SMVM_TX_COLCHK_EN: drop nonzeros whose column is out
// of range and flag them on the sticky err_col; otherwise err_col is 0.
module smvm_stream_tx #(
    parameter int K          = smvm_pkg::K,
    parameter int MAX_SHAPE  = 512,
    parameter int NZ_DEPTH   = 64,
    parameter int GAP_CYCLES = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_start,
    input  logic [8:0] s_rows,
    input  logic [8:0] s_cols,
    input  logic       s_vec_valid,
    output logic       s_vec_ready,
    input  logic [7:0] s_vec_data,
    input  logic       s_nz_valid,
    output logic       s_nz_ready,
    input  logic [7:0] s_nz_val,
    input  logic [8:0] s_nz_col,
    input  logic       s_nz_last,
    input  logic       s_nz_end,
    output logic [7:0] val_out,
    output logic       ipv_out,
    output logic       out_valid,
    output logic       busy,
    output logic       err_col
);
    import smvm_pkg::*;

    localparam int              SW       = $clog2(NZ_DEPTH + K) + 1;
    localparam logic [SW-1:0]   K_W      = SW'(K);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    tx_state_t        r_state;
    logic [IDX_W-1:0] r_rows;
    logic [IDX_W-1:0] r_cols;
    logic [IDX_W-1:0] r_vec_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cur_col;
    logic             r_end_seen;
    logic [SW-1:0]    r_sent;
    logic [7:0]       r_gap;
    logic [VAL_W-1:0] r_val_out;
    logic             r_ipv_out;
    logic             r_out_valid;
    logic [VAL_W-1:0] r_vec_ram [MAX_SHAPE];

    logic             w_vec_fire;
    logic             w_nz_fire;
    logic             w_end_fire;
    logic             w_col_bad;
    logic             w_push;
    logic             w_pop;
    logic             w_vec_done;
    logic             w_pad_due;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    nz_entry_t        w_push_entry;
    nz_entry_t        w_head;

    assign s_vec_ready = (r_state == ST_LOAD) && (r_vec_cnt < r_cols);
    assign s_nz_ready  = (r_state == ST_LOAD) && !w_fifo_full && !r_end_seen;

    assign w_vec_fire  = s_vec_ready && s_vec_valid;
    assign w_nz_fire   = s_nz_ready && s_nz_valid;
    // The end marker is honoured even without valid so an empty job can close LOAD.
    assign w_end_fire  = s_nz_ready && s_nz_end;
    assign w_push      = w_nz_fire && !w_col_bad;
    assign w_push_entry = {s_nz_val, s_nz_col, s_nz_last};

    assign w_vec_done  = (r_idx == r_cols);
    assign w_pad_due   = (r_sent % K_W) != '0;
    // The head is consumed when the vector is finished or after each IDX beat.
    assign w_pop       = !w_fifo_empty &&
                         ((r_state == ST_VEC && w_vec_done) || r_state == ST_IDX);

`ifdef SMVM_TX_COLCHK_EN
    logic r_err_col;
    assign w_col_bad = (s_nz_col >= r_cols);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_col <= 1'b0;
        end else if (r_state == ST_IDLE && s_start) begin
            r_err_col <= 1'b0;
        end else if (w_nz_fire && w_col_bad) begin
            r_err_col <= 1'b1;
        end
    end
    assign err_col = r_err_col;
`else
    assign w_col_bad = 1'b0;
    assign err_col   = 1'b0;
`endif

    smvm_nz_fifo #(
        .DEPTH (NZ_DEPTH),
        .W     ($bits(nz_entry_t))
    ) u_nz_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (w_vec_fire) begin
            r_vec_ram[r_vec_cnt] <= s_vec_data;
        end
    end

    // Outputs are loaded on entry to each state, so a beat is visible
    // for exactly the cycle the FSM sits in the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rows      <= '0;
            r_cols      <= '0;
            r_vec_cnt   <= '0;
            r_idx       <= '0;
            r_cur_col   <= '0;
            r_end_seen  <= 1'b0;
            r_sent      <= '0;
            r_gap       <= '0;
            r_val_out   <= '0;
            r_ipv_out   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_start) begin
                        r_state    <= ST_LOAD;
                        r_rows     <= s_rows;
                        r_cols     <= s_cols;
                        r_vec_cnt  <= '0;
                        r_end_seen <= 1'b0;
                        r_sent     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_vec_fire) r_vec_cnt  <= r_vec_cnt + IDX_W'(1);
                    if (w_end_fire) r_end_seen <= 1'b1;
                    if (r_vec_cnt == r_cols && r_end_seen) begin
                        r_state                <= ST_HDR0;
                        r_out_valid            <= 1'b1;
                        {r_val_out, r_ipv_out} <= split9(r_rows);
                    end
                end
                ST_HDR0: begin
                    r_state                <= ST_HDR1;
                    {r_val_out, r_ipv_out} <= split9(r_cols);
                end
                ST_HDR1: begin
                    r_state   <= ST_VEC;
                    r_val_out <= r_vec_ram[0];
                    r_ipv_out <= 1'b0;
                    r_idx     <= IDX_W'(1);
                end
                ST_VAL: begin
                    r_state                <= ST_IDX;
                    {r_val_out, r_ipv_out} <= split9(r_cur_col);
                    r_sent                 <= r_sent + SW'(1);
                end
                ST_VEC, ST_IDX: begin
                    if (r_state == ST_VEC && !w_vec_done) begin
                        r_val_out <= r_vec_ram[r_idx];
                        r_ipv_out <= 1'b0;
                        r_idx     <= r_idx + IDX_W'(1);
                    end else if (w_pop) begin
                        r_state   <= ST_VAL;
                        r_val_out <= w_head.val;
                        r_ipv_out <= w_head.last;
                        r_cur_col <= w_head.col;
                    end else if (w_pad_due) begin
                        // Pad entries complete the last ALU group.
                        r_state   <= ST_VAL;
                        r_val_out <= '0;
                        r_ipv_out <= 1'b0;
                        r_cur_col <= '0;
                    end else begin
                        r_state     <= ST_GAP;
                        r_out_valid <= 1'b0;
                        r_val_out   <= '0;
                        r_ipv_out   <= 1'b0;
                        r_gap       <= '0;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) r_state <= ST_IDLE;
                    else                   r_gap   <= r_gap + 8'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign val_out   = r_val_out;
    assign ipv_out   = r_ipv_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_smvm_stream_tx.sv
// tb/tb_smvm_stream_tx.sv - scoreboard bench for smvm_stream_tx
module tb_smvm_stream_tx;
    localparam int K   = 4;
    localparam int GAP = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_start = 1'b0;
    logic [8:0] s_rows = '0;
    logic [8:0] s_cols = '0;
    logic       s_vec_valid = 1'b0;
    logic       s_vec_ready;
    logic [7:0] s_vec_data = '0;
    logic       s_nz_valid = 1'b0;
    logic       s_nz_ready;
    logic [7:0] s_nz_val = '0;
    logic [8:0] s_nz_col = '0;
    logic       s_nz_last = 1'b0;
    logic       s_nz_end = 1'b0;
    logic [7:0] val_out;
    logic       ipv_out;
    logic       out_valid;
    logic       busy;
    logic       err_col;

    always #5 clk = ~clk;

    smvm_stream_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_start     (s_start),
        .s_rows      (s_rows),
        .s_cols      (s_cols),
        .s_vec_valid (s_vec_valid),
        .s_vec_ready (s_vec_ready),
        .s_vec_data  (s_vec_data),
        .s_nz_valid  (s_nz_valid),
        .s_nz_ready  (s_nz_ready),
        .s_nz_val    (s_nz_val),
        .s_nz_col    (s_nz_col),
        .s_nz_last   (s_nz_last),
        .s_nz_end    (s_nz_end),
        .val_out     (val_out),
        .ipv_out     (ipv_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .err_col     (err_col)
    );

    typedef struct packed {
        logic [7:0] val;
        logic [8:0] col;
        logic       last;
    } nz_t;

`ifdef SMVM_TX_COLCHK_EN
    bit colchk = 1'b1;
`else
    bit colchk = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_b;
    int         j_rows;
    int         j_cols;
    logic [7:0] j_vec[$];
    nz_t        j_nz[$];
    bit         throttle = 1'b0;
    bit         loading = 1'b0;
    bit         prev_ov = 1'b0;
    int         runs, cur_run, last_run, gap_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (loading) check_eq("early_out", 32'(out_valid), 32'd0);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("extra_beat", 32'(out_valid), 32'd0);
                end else begin
                    exp_b = sb.pop_front();
                    check_eq("beat", 32'({val_out, ipv_out}), 32'(exp_b));
                end
                if (!prev_ov) runs++;
                cur_run++;
                last_run = cur_run;
            end else begin
                cur_run = 0;
                if (busy && runs > 0) gap_cnt++;
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
            cur_run = 0;
        end
    end

    task automatic add_nz(input int v, input int c, input bit l);
        nz_t e;
        e.val  = 8'(v);
        e.col  = 9'(c);
        e.last = l;
        j_nz.push_back(e);
    endtask

    // Reference model of the frame: header, vector, kept nonzeros, K-padding.
    task automatic build_expected(output int len);
        int n = 0;
        int base = sb.size();
        sb.push_back(9'(j_rows));
        sb.push_back(9'(j_cols));
        foreach (j_vec[i]) sb.push_back({j_vec[i], 1'b0});
        foreach (j_nz[i]) begin
            if (!(colchk && int'(j_nz[i].col) >= j_cols)) begin
                sb.push_back({j_nz[i].val, j_nz[i].last});
                sb.push_back(j_nz[i].col);
                n++;
            end
        end
        while (n % K != 0) begin
            sb.push_back(9'd0);
            sb.push_back(9'd0);
            n++;
        end
        len = sb.size() - base;
    endtask

    task automatic drv_vec();
        int t;
        foreach (j_vec[i]) begin
            @(negedge clk);
            if (throttle) begin
                s_vec_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            s_vec_valid = 1'b1;
            s_vec_data  = j_vec[i];
            t = 0;
            while (!s_vec_ready && t < 500) begin @(negedge clk); t++; end
            if (t >= 500) check_eq("vec_hs_timeout", 32'(t), 32'd0);
        end
        @(negedge clk);
        s_vec_valid = 1'b0;
    endtask

    task automatic drv_nz();
        int t;
        int last_i = j_nz.size() - 1;
        if (j_nz.size() == 0) begin
            @(negedge clk);
            if (throttle) repeat ($urandom_range(0, 3)) @(negedge clk);
            s_nz_valid = 1'b0;
            s_nz_end   = 1'b1;
            t = 0;
            while (!s_nz_ready && t < 500) begin @(negedge clk); t++; end
            if (t >= 500) check_eq("nz_hs_timeout", 32'(t), 32'd0);
        end else begin
            foreach (j_nz[i]) begin
                @(negedge clk);
                if (throttle) begin
                    s_nz_valid = 1'b0;
                    s_nz_end   = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                s_nz_valid = 1'b1;
                s_nz_val   = j_nz[i].val;
                s_nz_col   = j_nz[i].col;
                s_nz_last  = j_nz[i].last;
                s_nz_end   = (i == last_i);
                t = 0;
                while (!s_nz_ready && t < 500) begin @(negedge clk); t++; end
                if (t >= 500) check_eq("nz_hs_timeout", 32'(t), 32'd0);
            end
        end
        @(negedge clk);
        s_nz_valid = 1'b0;
        s_nz_end   = 1'b0;
    endtask

    task automatic start_load(input bit stale, output int len);
        build_expected(len);
        runs = 0; last_run = 0; gap_cnt = 0;
        @(negedge clk);
        s_start = 1'b1;
        s_rows  = 9'(j_rows);
        s_cols  = 9'(j_cols);
        if (stale) begin
            s_vec_valid = 1'b1;
            s_vec_data  = 8'hEE;
        end
        check_eq("rdy_idle", 32'({s_vec_ready, s_nz_ready}), 32'd0);
        @(negedge clk);
        s_start     = 1'b0;
        s_vec_valid = 1'b0;
        check_eq("busy_load", 32'(busy), 32'd1);
        loading = 1'b1;
        fork
            drv_vec();
            drv_nz();
        join
        loading = 1'b0;
    endtask

    task automatic finish_frame(input int len, input bit poke);
        int t = 0;
        if (poke) begin
            repeat (4) @(negedge clk);
            check_eq("rdy_frame", 32'({s_vec_ready, s_nz_ready}), 32'd0);
            s_start = 1'b1;
            s_rows  = 9'h1FF;
            s_cols  = 9'h1FF;
            @(negedge clk);
            s_start = 1'b0;
        end
        while (busy && t < 3000) begin @(negedge clk); t++; end
        check_eq("done_timeout", 32'(busy), 32'd0);
        check_eq("frame_runs", 32'(runs), 32'd1);
        check_eq("frame_len", 32'(last_run), 32'(len));
        check_eq("gap_len", 32'(gap_cnt), 32'(GAP));
    endtask

    task automatic run_job(input bit stale, input bit poke);
        int len;
        start_load(stale, len);
        finish_frame(len, poke);
    endtask

    task automatic set_basic();
        j_rows = 2; j_cols = 3;
        j_vec.delete(); j_nz.delete();
        j_vec.push_back(8'd5); j_vec.push_back(8'd6); j_vec.push_back(8'd7);
        add_nz(1, 0, 1'b0); add_nz(2, 1, 1'b1); add_nz(3, 2, 1'b0); add_nz(4, 0, 1'b1);
    endtask

    task automatic set_random(input int rows, input int cols, input int nnz);
        j_rows = rows; j_cols = cols;
        j_vec.delete(); j_nz.delete();
        for (int i = 0; i < cols; i++) j_vec.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < nnz; i++)
            add_nz(int'($urandom_range(0, 255)), int'($urandom_range(0, cols - 1)),
                   1'($urandom_range(0, 1)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        int t;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_val_ipv", 32'({val_out, ipv_out}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'({s_vec_ready, s_nz_ready}), 32'd0);
        check_eq("rst_err_col", 32'(err_col), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_basic();
        run_job(1'b1, 1'b1);

        j_rows = 4; j_cols = 2;
        j_vec.delete(); j_nz.delete();
        j_vec.push_back(8'h11); j_vec.push_back(8'h22);
        for (int i = 0; i < 5; i++) add_nz(10 + i, i % 2, 1'(i & 1));
        run_job(1'b0, 1'b0);

        j_rows = 1; j_cols = 2;
        j_vec.delete(); j_nz.delete();
        j_vec.push_back(8'h33); j_vec.push_back(8'h44);
        run_job(1'b0, 1'b0);

        throttle = 1'b1;
        set_basic();
        run_job(1'b0, 1'b0);
        set_random(7, 12, 9);
        run_job(1'b0, 1'b0);
        set_random(300, 20, 16);
        run_job(1'b0, 1'b0);
        throttle = 1'b0;
        check_eq("err_col_tied", 32'(err_col), 32'(0));

        set_random(3, 40, 4);
        start_load(1'b0, len);
        t = 0;
        while (sb.size() > len - 10 && t < 500) begin @(negedge clk); t++; end
        @(posedge clk);
        #2;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_basic();
        run_job(1'b0, 1'b0);

`ifdef SMVM_TX_COLCHK_EN
        j_rows = 5; j_cols = 3;
        j_vec.delete(); j_nz.delete();
        j_vec.push_back(8'd9); j_vec.push_back(8'd8); j_vec.push_back(8'd7);
        add_nz(9, 1, 1'b0); add_nz(8, 3, 1'b1); add_nz(7, 2, 1'b1);
        run_job(1'b0, 1'b0);
        check_eq("err_col_set", 32'(err_col), 32'd1);
        j_nz.delete();
        start_load(1'b0, len);
        check_eq("err_col_clr", 32'(err_col), 32'd0);
        finish_frame(len, 1'b0);
`endif

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/smvm_stream_tx.md
Name: smvm_stream_tx

Overview:
- Host-side transmitter that serializes one sparse matrix-vector job into the SMVM input stream (val_out/ipv_out/out_valid, which drive SMVM val_in/ipv_in/in_valid).
- Buffers the dense vector and the nonzero list, then emits a gap-free frame, because the SMVM input has no backpressure.
- Pads the nonzero count to a multiple of K, then holds off the next frame until the SMVM has drained.

Parameters:
- K, 4: nonzeros per ALU group; the frame's nonzero count is padded to a multiple of K.
- MAX_SHAPE, 512: vector RAM depth. Valid cols range is 1..511.
- NZ_DEPTH, 64: nonzero FIFO depth, power of 2.
- GAP_CYCLES, 7: idle cycles forced after a frame. Covers SMVM CAL, RST and IDLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_start  in  1  job start pulse; sampled only in IDLE
- s_rows  in  9  row count, sampled with s_start
- s_cols  in  9  column count (1..511), sampled with s_start
- s_vec_valid / s_vec_ready  in / out  1 / 1  vector element handshake
- s_vec_data  in  8  vector element, in index order
- s_nz_valid / s_nz_ready  in / out  1 / 1  nonzero handshake
- s_nz_val  in  8  matrix value
- s_nz_col  in  9  column index
- s_nz_last  in  1  last nonzero of its row; becomes the IPV bit
- s_nz_end  in  1  marks the final nonzero of the job
- val_out  out  8  stream data
- ipv_out  out  1  stream side bit
- out_valid  out  1  stream valid
- busy  out  1  high whenever state != IDLE
- err_col  out  1  sticky column-range error (optional feature)

Behaviour:
- Clocking/reset: as already decided, clock clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0. State IDLE, FIFO empty, all counters 0. Reset mid-frame aborts immediately and out_valid drops asynchronously.

State machine:
- IDLE -> LOAD on s_start. Latch rows and cols; clear vec_cnt, nz_cnt and the end_seen flag.
- LOAD:
  - s_vec_ready = (vec_cnt < cols). Each accepted element is written to vec_ram[vec_cnt].
  - s_nz_ready = !fifo_full && !end_seen. Vector and nonzero channels are accepted concurrently.
  - Accepting an entry with s_nz_end=1 sets end_seen; a job with no nonzeros sends one entry with s_nz_end=1 and s_nz_valid=0, which sets end_seen without pushing.
  - LOAD -> HDR0 the cycle after (vec_cnt==cols && end_seen). First beat follows on the next clock.
  - If the FIFO is full without end, the block stalls. Keeping each job within NZ_DEPTH is an upstream rule.
- HDR0: val_out=rows[8:1], ipv_out=rows[0]. -> HDR1.
- HDR1: val_out=cols[8:1], ipv_out=cols[0]. -> VEC.
- VEC: val_out=vec_ram[i], ipv_out=0, for i=0..cols-1.
  - Then -> VAL if the FIFO holds entries, else -> GAP (zero-nonzero frame).
- VAL: pop the FIFO head; val_out=nz_val, ipv_out=nz_last. -> IDX.
  - Once the FIFO is empty while sent%K != 0, emit pad entries instead: val=0, col=0, ipv=0.
- IDX: val_out=col[8:1], ipv_out=col[0]; increment sent.
  - -> VAL if the FIFO is non-empty or sent%K != 0, else -> GAP.
- GAP: out_valid=0 for GAP_CYCLES cycles. -> IDLE.

Stream rules:
- out_valid=1 in HDR0, HDR1, VEC, VAL and IDX only. It never drops inside a frame.
- Frame length = 2 + cols + 2*ceil(nz/K)*K beats.
- s_start outside IDLE is ignored.
- Both s_*_ready are 0 outside LOAD.
- A simultaneous s_start and stale s_vec_valid in IDLE accepts nothing that cycle.

Optional Feature:
- Macro: SMVM_TX_COLCHK_EN.
- Enabled: in LOAD, an accepted nonzero with s_nz_col >= cols is dropped (handshake still completes) and err_col is set. Its s_nz_end is still honoured. err_col clears on the next s_start or on reset.
- Disabled: no check is made, every entry is pushed, and err_col is tied to 0.

Decomposition:
- Package smvm_pkg:
  - K, IDX_W=9, VAL_W=8, OUT_W=14
  - state encoding
  - split9 function: 9-bit value -> {val_out, ipv_out}
  - nz entry struct: val, col, last
- Sub-module smvm_nz_fifo: synchronous FIFO, NZ_DEPTH x 18 bits, with push/pop/full/empty and async reset.
- Vector RAM and FSM live in the top.

Test Plan:
- Basic frame: rows=2, cols=3, vec {5,6,7}, 4 nonzeros (val 1,2,3,4; col 0,1,2,0; last 0,1,0,1) -> beats {1,0},{1,1},{5,0},{6,0},{7,0}, then VAL/IDX pairs {1,0}/{0,0}, {2,1}/{0,1}, {3,0}/{1,0}, {4,1}/{0,0}; 13 beats contiguous; then 7 idle cycles and busy falls.
- Padding: 5 nonzeros -> 8 VAL/IDX pairs; pairs 6-8 are {0,0}/{0,0}; out_valid never gaps.
- Zero nonzeros: cols=2 -> exactly 4 valid beats, then GAP.
- Interleaved, throttled upstream (random valid gaps, vector and nonzero mixed) -> identical stream to the unthrottled case; no output before the final handshake.
- Reset mid-VEC: out_valid drops immediately; after release, s_start gives a clean full frame.
- With SMVM_TX_COLCHK_EN: cols=3, one entry with col=3 -> entry absent from the stream and err_col=1; cleared on the next s_start.
